ro_freq_counter: RTL and testbench



---
 rtl/ro_freq_counter.sv | 207 ++++++++++++++++++++
 tb/tb_ro_freq_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ro_freq_counter
//  Brief    : Ring-oscillator frequency counter. Synchronises the asynchronous
//             oscillator output into clk, counts its rising edges over a gate
//             window of 2^(GATE_LOG2_BASE + gate_sel) clk cycles and latches
//             the (saturating) result. f_osc = count * f_clk / window.
//  Options  : OSC_PRESCALE_EN - divide osc_in by 2 with a toggle flop clocked
//             by osc_in before synchronisation (count then reads f_osc/2).
//  Revision : 1.0 - initial release
// ============================================================================
module ro_freq_counter #(
    parameter int CNT_W          = 16,
    parameter int GATE_LOG2_BASE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             osc_in,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             done,
    output logic             busy,
    output logic             overflow
);

    // Timer must hold W-1 for the longest window (gate_sel = 3).
    localparam int TMR_W = GATE_LOG2_BASE + 3;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] c_tmr_one = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               arm_q, arm_d;
    logic [1:0]         gsel_q, gsel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               s1_q, s2_q, s3_q;
    logic               w_osc_src;
    logic               w_edge;
    logic               w_acc_full;

    // W-1 for a given window select, computed one bit wider so 2^TMR_W fits.
    function automatic logic [TMR_W-1:0] win_m1(input logic [1:0] g);
        logic [TMR_W:0] w;
        w = {{TMR_W{1'b0}}, 1'b1} << (GATE_LOG2_BASE + int'(g));
        w = w - {{TMR_W{1'b0}}, 1'b1};
        return w[TMR_W-1:0];
    endfunction

`ifdef OSC_PRESCALE_EN
    logic div_q;
    logic div_d;

    assign div_d = ~div_q;

    // Divide-by-2 toggle in the oscillator domain; halves the edge rate seen by clk.
    always_ff @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) div_q <= 1'b0;
        else        div_q <= div_d;
    end

    assign w_osc_src = div_q;
`else
    assign w_osc_src = osc_in;
`endif

    // Two-flop synchroniser plus an edge-detect flop on the oscillator input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= w_osc_src;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign w_edge     = s2_q & ~s3_q;
    assign w_acc_full = (acc_q == c_cnt_max);

    // Next-state and datapath: sequencing IDLE -> ARM (2 cycles) -> GATE (W cycles).
    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        gsel_d     = gsel_q;
        timer_d    = timer_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && ena) begin
                    gsel_d  = gate_sel;
                    arm_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else begin
                    // Synchroniser keeps running here so stale samples drain out.
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    timer_d   = win_m1(gsel_q);
                    if (arm_q) state_d = ST_GATE;
                    else       arm_d   = 1'b1;
                end
            end

            ST_GATE: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    // Fold the final cycle's edge straight into the result.
                    if (w_edge && w_acc_full) begin
                        count_d    = c_cnt_max;
                        overflow_d = 1'b1;
                    end else begin
                        count_d    = w_edge ? (acc_q + c_cnt_one) : acc_q;
                        overflow_d = ovf_acc_q;
                    end
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    if (cont) begin
                        // Back-to-back window: no ARM, no lost cycle.
                        timer_d   = win_m1(gsel_q);
                        acc_d     = '0;
                        ovf_acc_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - c_tmr_one;
                    if (w_edge) begin
                        if (w_acc_full) ovf_acc_d = 1'b1;
                        else            acc_d     = acc_q + c_cnt_one;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            gsel_q     <= 2'd0;
            timer_q    <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            gsel_q     <= gsel_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ro_freq_counter
//  Brief    : Self-checking bench for ro_freq_counter (CNT_W = 8). A periodic
//             oscillator of P clk cycles yields floor(W/P)..ceil(W/P) edges in
//             any W-cycle window; results saturate at 255 with overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ro_freq_counter;

    localparam int CNT_W = 8;
    localparam int BASE  = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             ena      = 1'b0;
    logic             osc_in   = 1'b0;
    logic             start    = 1'b0;
    logic             cont     = 1'b0;
    logic [1:0]       gate_sel = 2'd0;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             done;
    logic             busy;
    logic             overflow;

    ro_freq_counter #(
        .CNT_W          (CNT_W),
        .GATE_LOG2_BASE (BASE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .osc_in   (osc_in),
        .start    (start),
        .cont     (cont),
        .gate_sel (gate_sel),
        .count    (count),
        .valid    (valid),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else    $display("FAIL %s: %s", name, msg);
    endtask

    // Oscillator model: period osc_p clk cycles (0 = held low), high for osc_p/2.
    int osc_p = 0;
    initial begin : osc_gen
        int ph;
        int last_p;
        ph     = 0;
        last_p = 0;
        forever begin
            @(negedge clk);
            if (osc_p != last_p) begin
                ph     = 0;
                last_p = osc_p;
            end
            if (osc_p == 0) begin
                osc_in = 1'b0;
            end else begin
                osc_in = (ph < osc_p / 2);
                ph     = (ph + 1) % osc_p;
            end
        end
    end

    typedef struct {
        int          lo;
        int          hi;
        int unsigned due;
    } exp_t;

    exp_t sb[$];

    // Monitor: every done pulse must match the oldest expected window result.
    exp_t m_e;
    bit   m_ok;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_done", $sformatf("done at cycle %0d, none expected", cyc));
            end else begin
                m_e  = sb.pop_front();
                m_ok = 1'b0;
                for (int n = m_e.lo; n <= m_e.hi; n++) begin
                    if (int'(count) == ((n > CMAX) ? CMAX : n) && overflow == (n > CMAX))
                        m_ok = 1'b1;
                end
                chk(m_ok, "count", $sformatf("count=%0d overflow=%0d, want %0d..%0d edges (sat %0d)",
                                             count, overflow, m_e.lo, m_e.hi, CMAX));
                chk(cyc == m_e.due, "done_cycle", $sformatf("done at %0d, want %0d", cyc, m_e.due));
                chk(valid == 1'b1, "valid_at_done", $sformatf("valid=%0d, want 1", valid));
            end
        end
    end

    // One measurement of nwin windows at period p and window select gs.
    task automatic run(input int p, input int gs, input int nwin, input bit do_cont);
        int          w;
        int unsigned c0;
        int          busy_n;
        exp_t        e;
        osc_p = p;
        repeat (12) @(negedge clk);
        w        = 1 << (BASE + gs);
        gate_sel = 2'(gs);
        cont     = do_cont;
        ena      = 1'b1;
        start    = 1'b1;
        c0       = cyc;
        for (int i = 0; i < nwin; i++) begin
            e.lo  = (p == 0) ? 0 : w / p;
            e.hi  = (p == 0) ? 0 : (w + p - 1) / p;
            e.due = c0 + 3 + w * (i + 1);
            sb.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        busy_n = 0;
        while (busy && busy_n < nwin * w + 50) begin
            busy_n++;
            gate_sel = 2'($urandom_range(0, 3));
            start    = (cyc == c0 + 3 + w / 3);
            if (do_cont && cyc == c0 + 3 + w * (nwin - 1) + w / 2) cont = 1'b0;
            if (nwin > 1 && cyc == c0 + 3 + w + w / 2)
                chk(valid == 1'b1, "valid_cont", $sformatf("valid=%0d between windows, want 1", valid));
            @(negedge clk);
        end
        start = 1'b0;
        cont  = 1'b0;
        chk(busy_n == nwin * w + 2, "busy_len", $sformatf("busy %0d cycles, want %0d", busy_n, nwin * w + 2));
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        chk(sb.size() == 0, "sb_drain", $sformatf("%0d results outstanding, want 0", sb.size()));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int p;
        int gs;
        int nw;
        repeat (3) @(negedge clk);
        chk(count == '0 && valid == 1'b0 && busy == 1'b0 && overflow == 1'b0 && done == 1'b0,
            "reset_state", $sformatf("count=%0d valid=%0d busy=%0d ovf=%0d done=%0d, want all 0",
                                     count, valid, busy, overflow, done));
        rst_n = 1'b1;
        ena   = 1'b1;

        // Basic clk/4 measurement, then zero-edge input at gate_sel=2.
        run(4, 0, 1, 1'b0);
        run(0, 2, 1, 1'b0);
        // Saturation at the longest window, then a clean run clears overflow.
        run(4, 3, 1, 1'b0);
        run(4, 0, 1, 1'b0);
        // Continuous mode, three back-to-back windows, cont dropped in the last.
        run(8, 1, 3, 1'b1);

        // ena=0 mid-window aborts without a result; prior count of 64 kept.
        osc_p = 4;
        repeat (12) @(negedge clk);
        gate_sel = 2'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk(busy == 1'b0, "abort_busy", $sformatf("busy=%0d after ena=0, want 0", busy));
        chk(count == 8'd64 && overflow == 1'b0, "abort_keep",
            $sformatf("count=%0d ovf=%0d, want 64/0", count, overflow));
        repeat (300) @(negedge clk);

        // start with ena=0 is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk(busy == 1'b0, "start_no_ena", $sformatf("busy=%0d, want 0", busy));
        ena = 1'b1;

        // Asynchronous reset mid-window clears everything before the next edge.
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk(count == '0 && valid == 1'b0 && busy == 1'b0 && overflow == 1'b0 && done == 1'b0,
            "async_reset", $sformatf("count=%0d valid=%0d busy=%0d ovf=%0d done=%0d, want all 0",
                                     count, valid, busy, overflow, done));
        @(negedge clk);
        rst_n = 1'b1;
        run(4, 0, 1, 1'b0);

        // Randomised measurements against the edge-count model.
        for (int r = 0; r < 8; r++) begin
            p = $urandom_range(2, 24);
            if (p == 2) p = 0;
            gs = $urandom_range(0, 3);
            nw = (gs >= 2) ? 1 : $urandom_range(1, 3);
            run(p, gs, nw, (nw > 1) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
